ring_phase_monitor: RTL and testbench

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

---
 rtl/ring_mon_pkg.sv | 12 +
 rtl/onehot_enc4.sv | 24 ++
 rtl/ring_phase_monitor.sv | 111 +++++++++++
 tb/tb_ring_phase_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_mon_pkg.sv
// Shared encodings for the ring phase monitor: FSM states and ring width.
package ring_mon_pkg;

    localparam int RING_W = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        LOCKED = 2'b01,
        FAULT  = 2'b10
    } state_t;

endpackage

// File: rtl/onehot_enc4.sv
// Purpose: encode a 4-bit phase vector into index plus one-hot/zero qualifiers.
// Latency: purely combinational.
// Backpressure: none.
module onehot_enc4
    import ring_mon_pkg::*;
(
    input  logic [RING_W-1:0] vec,
    output logic [1:0]        idx,
    output logic              is_onehot,
    output logic              is_zero
);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < RING_W; i++) begin
            if (vec[i]) idx = 2'(i);
        end
    end

    // A value with exactly one bit set has no bits left after clearing the lowest one.
    assign is_zero   = (vec == '0);
    assign is_onehot = !is_zero && ((vec & (vec - 4'd1)) == '0);

endmodule

// File: rtl/ring_phase_monitor.sv
// Purpose: lock onto an upstream 4-bit ring counter, track phase/rotations, flag faults.
// Latency: ring_in sampled at edge N is reflected on outputs after edge N+1.
// Backpressure: none; ring_in is accepted every cycle, an upstream stall is a legal hold.
module ring_phase_monitor
    import ring_mon_pkg::*;
#(
    parameter int ROT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RING_W-1:0] ring_in,
    input  logic              clr_err,
    output logic [1:0]        phase,
    output logic              phase_valid,
    output logic [ROT_W-1:0]  rot_count,
    output logic              rot_tick,
    output logic              err_onehot,
    output logic              err_seq,
    output logic [1:0]        fsm_state
);

    logic [RING_W-1:0] ring_q;
    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ROT_W-1:0]  rot_q, rot_d;
    logic              tick_q, tick_d;
    logic              eoh_q, eoh_d;
    logic              eseq_q, eseq_d;

    logic [1:0] enc_idx;
    logic       enc_onehot;
    logic       enc_zero;

    onehot_enc4 u_enc (
        .vec       (ring_q),
        .idx       (enc_idx),
        .is_onehot (enc_onehot),
        .is_zero   (enc_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ring_q  <= '0;
            state_q <= SEARCH;
            phase_q <= 2'd0;
            rot_q   <= '0;
            tick_q  <= 1'b0;
            eoh_q   <= 1'b0;
            eseq_q  <= 1'b0;
        end else begin
            ring_q  <= ring_in;
            state_q <= state_d;
            phase_q <= phase_d;
            rot_q   <= rot_d;
            tick_q  <= tick_d;
            eoh_q   <= eoh_d;
            eseq_q  <= eseq_d;
        end
    end

    // Clear is applied first so a newly detected error below overrides it.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rot_d   = rot_q;
        tick_d  = 1'b0;
        eoh_d   = clr_err ? 1'b0 : eoh_q;
        eseq_d  = clr_err ? 1'b0 : eseq_q;

        unique case (state_q)
            SEARCH: begin
                if (enc_onehot) begin
                    phase_d = enc_idx;
                    state_d = LOCKED;
                end else if (!enc_zero) begin
                    eoh_d = 1'b1;
                end
            end
            LOCKED: begin
                if (enc_onehot && (enc_idx == phase_q)) begin
                    phase_d = phase_q;
                end else if (enc_onehot && (enc_idx == phase_q + 2'd1)) begin
                    phase_d = enc_idx;
                    if (phase_q == 2'd3) begin
                        rot_d  = rot_q + ROT_W'(1);
                        tick_d = 1'b1;
                    end
                end else if (enc_onehot) begin
                    eseq_d  = 1'b1;
                    state_d = FAULT;
                end else begin
                    eoh_d   = 1'b1;
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (clr_err) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    assign phase       = phase_q;
    assign phase_valid = (state_q == LOCKED);
    assign rot_count   = rot_q;
    assign rot_tick    = tick_q;
    assign err_onehot  = eoh_q;
    assign err_seq     = eseq_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: a behavioural model predicts outputs, a monitor compares.
module tb_ring_phase_monitor;

    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    ring_in;
    logic          clr_err;
    logic [1:0]    phase;
    logic          phase_valid;
    logic [RW-1:0] rot_count;
    logic          rot_tick;
    logic          err_onehot;
    logic          err_seq;
    logic [1:0]    fsm_state;

    ring_phase_monitor #(.ROT_W(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ring_in     (ring_in),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_valid (phase_valid),
        .rot_count   (rot_count),
        .rot_tick    (rot_tick),
        .err_onehot  (err_onehot),
        .err_seq     (err_seq),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int ph;
        int pv;
        int rc;
        int tk;
        int eo;
        int es;
        int st;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   neg_cnt = 0;

    // Reference model: mode 0=searching, 1=locked, 2=faulted.
    int         m_mode, m_ph, m_cnt, m_eo, m_es, m_tk;
    logic [3:0] m_prev;
    logic [3:0] cur;

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic int ones(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic int bitpos(input logic [3:0] v);
        int p = 0;
        for (int i = 0; i < 4; i++) if (v[i]) p = i;
        return p;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_cnt = 0; m_eo = 0; m_es = 0; m_tk = 0;
        m_prev = 4'b0000;
    endtask

    task automatic model_step(input logic [3:0] r, input logic c);
        m_tk = 0;
        if (c) begin
            m_eo = 0;
            m_es = 0;
        end
        if (m_mode == 0) begin
            if (ones(r) == 1) begin
                m_ph   = bitpos(r);
                m_mode = 1;
            end else if (r != 0) begin
                m_eo = 1;
            end
        end else if (m_mode == 1) begin
            if (ones(r) == 1 && bitpos(r) == m_ph) begin
                m_ph = m_ph;
            end else if (ones(r) == 1 && bitpos(r) == (m_ph + 1) % 4) begin
                if (m_ph == 3) begin
                    m_cnt = (m_cnt + 1) % (1 << RW);
                    m_tk  = 1;
                end
                m_ph = bitpos(r);
            end else if (ones(r) == 1) begin
                m_es   = 1;
                m_mode = 2;
            end else begin
                m_eo   = 1;
                m_mode = 2;
            end
        end else begin
            if (c) m_mode = 0;
        end
    endtask

    // Inputs change just after the rising edge; their effect is visible two falling edges later.
    task automatic drive(input logic [3:0] r, input logic c);
        exp_t e;
        @(posedge clk);
        #1;
        ring_in = r;
        clr_err = c;
        cur     = r;
        model_step(m_prev, c);
        m_prev = r;
        e.due = neg_cnt + 2;
        e.ph  = m_ph;
        e.pv  = (m_mode == 1) ? 1 : 0;
        e.rc  = m_cnt;
        e.tk  = m_tk;
        e.eo  = m_eo;
        e.es  = m_es;
        e.st  = m_mode;
        sb.push_back(e);
    endtask

    task automatic chk_reset_vals();
        chk("rst_phase", int'(phase), 0);
        chk("rst_phase_valid", int'(phase_valid), 0);
        chk("rst_rot_count", int'(rot_count), 0);
        chk("rst_rot_tick", int'(rot_tick), 0);
        chk("rst_err_onehot", int'(err_onehot), 0);
        chk("rst_err_seq", int'(err_seq), 0);
        chk("rst_fsm_state", int'(fsm_state), 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        ring_in = 4'b0000;
        clr_err = 1'b0;
        sb.delete();
        #2;
        chk_reset_vals();
        #48;
        model_reset();
        cur   = 4'b0000;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        neg_cnt++;
        while (sb.size() > 0 && sb[0].due <= neg_cnt) begin
            e = sb.pop_front();
            chk("phase", int'(phase), e.ph);
            chk("phase_valid", int'(phase_valid), e.pv);
            chk("rot_count", int'(rot_count), e.rc);
            chk("rot_tick", int'(rot_tick), e.tk);
            chk("err_onehot", int'(err_onehot), e.eo);
            chk("err_seq", int'(err_seq), e.es);
            chk("fsm_state", int'(fsm_state), e.st);
        end
    end

    initial begin
        logic [3:0] seq5 [5];
        logic [3:0] r;
        int p;
        seq5[0] = 4'b0001; seq5[1] = 4'b0010; seq5[2] = 4'b0100;
        seq5[3] = 4'b1000; seq5[4] = 4'b0001;

        reset   = 1'b0;
        ring_in = 4'b0000;
        clr_err = 1'b0;
        cur     = 4'b0000;
        model_reset();
        #3;
        chk_reset_vals();
        #97;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // One full rotation from acquisition.
        for (int i = 0; i < 5; i++) drive(seq5[i], 1'b0);
        // Stall at phase 1, then advance.
        for (int i = 0; i < 5; i++) drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        // Back to phase 1, then out-of-sequence jump with clear arriving on the same update.
        drive(4'b1000, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        drive(4'b1000, 1'b0);
        drive(4'b1000, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
        // Multi-hot while searching, then lock at phase 2 keeping the sticky flag.
        drive(4'b0110, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        // Four rotations to wrap the 2-bit counter.
        for (int i = 0; i < 16; i++) drive(4'b0001 << ((3 + i) % 4), 1'b0);
        drive(4'b1000, 1'b0);
        drive(4'b1000, 1'b0);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);

        // Lock, reach rot_count 3 at phase 2, then reset mid-rotation.
        reset_pulse();
        for (int i = 0; i < 15; i++) drive(4'b0001 << (i % 4), 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        reset_pulse();
        for (int i = 0; i < 6; i++) drive(4'b0001 << (i % 4), 1'b0);

        // Randomized traffic: mostly legal advances, some stalls, junk and clears.
        for (int n = 0; n < 600; n++) begin
            p = $urandom_range(99);
            if (p < 60)      r = (ones(cur) == 1) ? {cur[2:0], cur[3]} : 4'b0001;
            else if (p < 80) r = cur;
            else if (p < 94) r = 4'($urandom_range(15));
            else             r = 4'b0000;
            drive(r, ($urandom_range(19) == 0));
        end

        repeat (4) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
